parser_comando_serial: RTL and testbench

Parametrised ASCII command-frame parser that sits between the 8N1 serial receiver and the control logic (PWM/weighing datapath). It takes one received byte per valid strobe and accepts frames of one command digit followed by NUM_CAMPOS decimal fields of exactly DIGITOS ASCII digits each. Each field is converted to binary, and all fields are released atomically with a one-cycle `pronto` pulse. Malformed frames, stalled frames and overflowing fields are rejected with an error code; previously published values are never corrupted.

---
 rtl/parser_comando_serial.sv | 143 ++++++++++++++
 tb/tb_parser_comando_serial.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parser_comando_serial.sv
// ASCII command-frame parser: one command digit followed by NUM_CAMPOS decimal fields
// of DIGITOS digits each. Fields are published atomically on a one-cycle pronto pulse.
module parser_comando_serial #(
  parameter int NUM_CAMPOS     = 3,
  parameter int DIGITOS        = 2,
  parameter int LARGURA        = 8,
  parameter int TIMEOUT_CICLOS = 5_000_000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [7:0]                    dado,
  input  logic                          dado_valido,
  output logic [3:0]                    comando,
  output logic [NUM_CAMPOS*LARGURA-1:0] campos,
  output logic                          pronto,
  output logic                          erro,
  output logic [1:0]                    codigo_erro,
  output logic                          ocupado,
  output logic [1:0]                    o_estado
);

  localparam int ACC_W = LARGURA + 4;
  localparam int CNT_W = $clog2(TIMEOUT_CICLOS + 1);
  localparam int IDX_W = $clog2(NUM_CAMPOS + 1);
  localparam int DIG_W = $clog2(DIGITOS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CICLOS - 1);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    CAMPO  = 2'd1,
    FIM    = 2'd2,
    ERRO   = 2'd3
  } estado_t;

  estado_t                         r_estado;
  logic [3:0]                      r_cmd;
  logic [IDX_W-1:0]                r_idx;
  logic [DIG_W-1:0]                r_dig;
  logic [ACC_W-1:0]                r_acc;
  logic [CNT_W-1:0]                r_cnt;
  logic [NUM_CAMPOS*LARGURA-1:0]   r_shadow;

  logic                            w_is_digit;
  logic [ACC_W-1:0]                w_acc_next;
  logic                            w_overflow;
  logic                            w_last_digit;
  logic                            w_last_field;
  logic [NUM_CAMPOS*LARGURA-1:0]   w_shadow_next;

  // ASCII '0'..'9' carry the digit value in the low nibble.
  assign w_is_digit   = (dado >= 8'h30) && (dado <= 8'h39);
  assign w_acc_next   = r_acc * ACC_W'(10) + ACC_W'(dado[3:0]);
  assign w_overflow   = |w_acc_next[ACC_W-1:LARGURA];
  assign w_last_digit = (r_dig == DIG_W'(DIGITOS - 1));
  assign w_last_field = (r_idx == IDX_W'(NUM_CAMPOS - 1));
  assign o_estado     = r_estado;

  always_comb begin
    w_shadow_next = r_shadow;
    for (int i = 0; i < NUM_CAMPOS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_shadow_next[i*LARGURA +: LARGURA] = w_acc_next[LARGURA-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado    <= OCIOSO;
      r_cmd       <= '0;
      r_idx       <= '0;
      r_dig       <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_shadow    <= '0;
      comando     <= '0;
      campos      <= '0;
      pronto      <= 1'b0;
      erro        <= 1'b0;
      codigo_erro <= 2'd0;
      ocupado     <= 1'b0;
    end else begin
      pronto <= 1'b0;
      erro   <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          if (dado_valido && w_is_digit) begin
            r_cmd    <= dado[3:0];
            r_idx    <= '0;
            r_dig    <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_estado <= CAMPO;
            ocupado  <= 1'b1;
          end
        end
        CAMPO: begin
          // A byte arriving on the terminal count wins over the timeout.
          if (dado_valido) begin
            r_cnt <= '0;
            if (!w_is_digit) begin
              r_estado    <= ERRO;
              erro        <= 1'b1;
              codigo_erro <= 2'd1;
              ocupado     <= 1'b0;
            end else if (w_overflow) begin
              r_estado    <= ERRO;
              erro        <= 1'b1;
              codigo_erro <= 2'd3;
              ocupado     <= 1'b0;
            end else if (w_last_digit) begin
              r_shadow <= w_shadow_next;
              r_acc    <= '0;
              r_dig    <= '0;
              r_idx    <= r_idx + IDX_W'(1);
              if (w_last_field) begin
                campos   <= w_shadow_next;
                comando  <= r_cmd;
                pronto   <= 1'b1;
                ocupado  <= 1'b0;
                r_estado <= FIM;
              end
            end else begin
              r_acc <= w_acc_next;
              r_dig <= r_dig + DIG_W'(1);
            end
          end else if (r_cnt == CNT_MAX) begin
            r_estado    <= ERRO;
            erro        <= 1'b1;
            codigo_erro <= 2'd2;
            ocupado     <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        FIM:     r_estado <= OCIOSO;
        ERRO:    r_estado <= OCIOSO;
        default: r_estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_parser_comando_serial.sv
// Bench for parser_comando_serial: a 3x2-digit instance and a 1x3-digit instance for overflow.
// Expected publish/error events are queued as bytes are driven and popped on each pulse.
module tb_parser_comando_serial;

  localparam int TMO = 10000;
  localparam int GAP = 20;
  localparam int WA  = 1 + 4 + 24 + 2;
  localparam int WB  = 1 + 4 + 8 + 2;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  dado_a, dado_b;
  logic        val_a, val_b;
  logic [3:0]  comando_a, comando_b;
  logic [23:0] campos_a;
  logic [7:0]  campos_b;
  logic        pronto_a, pronto_b, erro_a, erro_b, ocupado_a, ocupado_b;
  logic [1:0]  codigo_a, codigo_b, estado_a, estado_b;

  logic [WA-1:0] exp_q[$];
  logic [WB-1:0] exp_b_q[$];
  logic [WA-1:0] got_a, want_a;
  logic [WB-1:0] got_b, want_b;
  logic [3:0]    model_cmd_a, model_cmd_b;
  logic [23:0]   model_campos_a;
  logic [7:0]    model_campos_b;

  int tests_run = 0;
  int tests_failed = 0;

  always #10 clock = ~clock;

  parser_comando_serial #(.NUM_CAMPOS(3), .DIGITOS(2), .LARGURA(8), .TIMEOUT_CICLOS(TMO)) u_dut (
    .clock(clock), .reset(reset), .dado(dado_a), .dado_valido(val_a),
    .comando(comando_a), .campos(campos_a), .pronto(pronto_a), .erro(erro_a),
    .codigo_erro(codigo_a), .ocupado(ocupado_a), .o_estado(estado_a)
  );

  parser_comando_serial #(.NUM_CAMPOS(1), .DIGITOS(3), .LARGURA(8), .TIMEOUT_CICLOS(TMO)) u_ovf (
    .clock(clock), .reset(reset), .dado(dado_b), .dado_valido(val_b),
    .comando(comando_b), .campos(campos_b), .pronto(pronto_b), .erro(erro_b),
    .codigo_erro(codigo_b), .ocupado(ocupado_b), .o_estado(estado_b)
  );

  // Expected event layout: {is_error, comando, campos, codigo (0 for publishes)}.
  function automatic void push_pronto_a(input logic [3:0] c, input logic [23:0] f);
    model_cmd_a    = c;
    model_campos_a = f;
    exp_q.push_back({1'b0, c, f, 2'd0});
  endfunction

  function automatic void push_erro_a(input logic [1:0] code);
    exp_q.push_back({1'b1, model_cmd_a, model_campos_a, code});
  endfunction

  function automatic void push_pronto_b(input logic [3:0] c, input logic [7:0] f);
    model_cmd_b    = c;
    model_campos_b = f;
    exp_b_q.push_back({1'b0, c, f, 2'd0});
  endfunction

  function automatic void push_erro_b(input logic [1:0] code);
    exp_b_q.push_back({1'b1, model_cmd_b, model_campos_b, code});
  endfunction

  always @(negedge clock) begin
    if (!reset && (pronto_a || erro_a)) begin
      tests_run++;
      got_a = {erro_a, comando_a, campos_a, erro_a ? codigo_a : 2'd0};
      if (pronto_a && erro_a) begin
        tests_failed++;
        $display("FAIL mon_a_both: pronto and erro together got=%h", got_a);
      end else if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL mon_a_unexpected: got=%h required=no pulse", got_a);
      end else begin
        want_a = exp_q.pop_front();
        if (got_a !== want_a) begin
          tests_failed++;
          $display("FAIL mon_a_event: got=%h required=%h", got_a, want_a);
        end
      end
    end
    if (!reset && (pronto_b || erro_b)) begin
      tests_run++;
      got_b = {erro_b, comando_b, campos_b, erro_b ? codigo_b : 2'd0};
      if (pronto_b && erro_b) begin
        tests_failed++;
        $display("FAIL mon_b_both: pronto and erro together got=%h", got_b);
      end else if (exp_b_q.size() == 0) begin
        tests_failed++;
        $display("FAIL mon_b_unexpected: got=%h required=no pulse", got_b);
      end else begin
        want_b = exp_b_q.pop_front();
        if (got_b !== want_b) begin
          tests_failed++;
          $display("FAIL mon_b_event: got=%h required=%h", got_b, want_b);
        end
      end
    end
  end

  task automatic send_byte(input bit sel, input logic [7:0] b, input int gap);
    @(negedge clock);
    if (sel) begin dado_b = b; val_b = 1'b1; end
    else     begin dado_a = b; val_a = 1'b1; end
    @(negedge clock);
    val_a = 1'b0;
    val_b = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  task automatic send_str(input bit sel, input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_byte(sel, s[i], gap);
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((exp_q.size() != 0 || exp_b_q.size() != 0) && k < 2000) begin
      @(negedge clock);
      k++;
    end
    tests_run++;
    if (exp_q.size() != 0 || exp_b_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_drain: pending a=%0d b=%0d required=0", name, exp_q.size(), exp_b_q.size());
      exp_q.delete();
      exp_b_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; val_a = 1'b0; val_b = 1'b0; dado_a = 8'h00; dado_b = 8'h00;
    model_cmd_a = '0; model_campos_a = '0; model_cmd_b = '0; model_campos_b = '0;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    tests_run++;
    if ({comando_a, campos_a} !== 28'd0) begin
      tests_failed++; $display("FAIL reset_a_data: got=%h required=0", {comando_a, campos_a});
    end
    tests_run++;
    if ({pronto_a, erro_a, codigo_a, ocupado_a, estado_a} !== 7'd0) begin
      tests_failed++; $display("FAIL reset_a_ctrl: got=%b required=0", {pronto_a, erro_a, codigo_a, ocupado_a, estado_a});
    end
    tests_run++;
    if ({comando_b, campos_b, pronto_b, erro_b, codigo_b, ocupado_b, estado_b} !== 19'd0) begin
      tests_failed++; $display("FAIL reset_b: got=%h required=0", {comando_b, campos_b, pronto_b, erro_b, codigo_b, ocupado_b, estado_b});
    end
  endtask

  task automatic test_good_frame();
    push_pronto_a(4'd0, {8'd15, 8'd20, 8'd10});
    send_str(0, "0102015", GAP);
    drain("good_frame");
  endtask

  task automatic test_non_digit();
    push_erro_a(2'd1);
    send_str(0, "01A", GAP);
    drain("non_digit");
    tests_run++;
    if (ocupado_a !== 1'b0 || estado_a !== 2'd0) begin
      tests_failed++; $display("FAIL non_digit_idle: ocupado=%b estado=%0d required=0/0", ocupado_a, estado_a);
    end
    push_pronto_a(4'd3, {8'd7, 8'd6, 8'd5});
    send_str(0, "3050607", GAP);
    drain("after_error");
    tests_run++;
    if (codigo_a !== 2'd1) begin
      tests_failed++; $display("FAIL codigo_hold: got=%0d required=1", codigo_a);
    end
  endtask

  task automatic test_timeout();
    int k = 0;
    push_erro_a(2'd2);
    send_byte(0, "0", GAP);
    send_byte(0, "1", 0);
    tests_run++;
    if (ocupado_a !== 1'b1) begin
      tests_failed++; $display("FAIL timeout_busy: ocupado=%b required=1", ocupado_a);
    end
    while (!erro_a && k < TMO + 100) begin
      @(negedge clock);
      k++;
    end
    tests_run++;
    if (k !== TMO) begin
      tests_failed++; $display("FAIL timeout_latency: got=%0d cycles required=%0d", k, TMO);
    end
    tests_run++;
    if (ocupado_a !== 1'b0) begin
      tests_failed++; $display("FAIL timeout_ocupado: got=%b required=0", ocupado_a);
    end
    drain("timeout");
  endtask

  task automatic test_overflow();
    push_erro_b(2'd3);
    send_str(1, "0300", GAP);
    drain("overflow_300");
    push_pronto_b(4'd0, 8'd255);
    send_str(1, "0255", GAP);
    drain("max_255");
    push_erro_b(2'd3);
    send_str(1, "7256", GAP);
    drain("overflow_256");
    push_pronto_b(4'd4, 8'd0);
    send_str(1, "4000", GAP);
    drain("zero_field");
  endtask

  task automatic test_reset_mid();
    send_str(0, "010", GAP);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_cmd_a = '0; model_campos_a = '0; model_cmd_b = '0; model_campos_b = '0;
    tests_run++;
    if ({comando_a, campos_a, pronto_a, erro_a, codigo_a, ocupado_a, estado_a} !== 35'd0) begin
      tests_failed++; $display("FAIL reset_mid_a: got=%h required=0", {comando_a, campos_a, pronto_a, erro_a, codigo_a, ocupado_a, estado_a});
    end
    tests_run++;
    if ({comando_b, campos_b, codigo_b} !== 14'd0) begin
      tests_failed++; $display("FAIL reset_mid_b: got=%h required=0", {comando_b, campos_b, codigo_b});
    end
    push_pronto_a(4'd9, {8'd56, 8'd34, 8'd12});
    send_str(0, "9123456", GAP);
    drain("reset_mid");
  endtask

  task automatic test_noise();
    send_byte(0, 8'h0D, GAP);
    send_byte(0, 8'h0A, GAP);
    send_byte(0, 8'h20, GAP);
    tests_run++;
    if (ocupado_a !== 1'b0 || codigo_a !== 2'd0) begin
      tests_failed++; $display("FAIL noise_idle: ocupado=%b codigo=%0d required=0/0", ocupado_a, codigo_a);
    end
    push_pronto_a(4'd0, {8'd15, 8'd20, 8'd10});
    send_str(0, "0102015", GAP);
    drain("noise");
  endtask

  // Random frames with minimal spacing; one frame gets a stray byte during the publish cycle.
  task automatic test_back_to_back();
    logic [7:0] b [7];
    logic [6:0] f [3];
    logic [3:0] c;
    for (int n = 0; n < 6; n++) begin
      c = 4'($urandom_range(0, 9));
      for (int j = 0; j < 3; j++) f[j] = 7'($urandom_range(0, 99));
      b[0] = 8'h30 + 8'(c);
      for (int j = 0; j < 3; j++) begin
        b[1 + 2*j] = 8'h30 + 8'(f[j] / 10);
        b[2 + 2*j] = 8'h30 + 8'(f[j] % 10);
      end
      push_pronto_a(c, {1'b0, f[2], 1'b0, f[1], 1'b0, f[0]});
      for (int j = 0; j < 6; j++) send_byte(0, b[j], $urandom_range(0, 4));
      if (n == 2) begin
        @(negedge clock);
        dado_a = b[6]; val_a = 1'b1;
        @(negedge clock);
        dado_a = "5";
        @(negedge clock);
        val_a = 1'b0;
      end else begin
        send_byte(0, b[6], 0);
      end
    end
    drain("back_to_back");
    tests_run++;
    if (estado_a !== 2'd0) begin
      tests_failed++; $display("FAIL stray_dropped: estado=%0d required=0", estado_a);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_non_digit();
    test_timeout();
    test_overflow();
    test_reset_mid();
    test_noise();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
